bid_round_ctrl: RTL and testbench

BID_ROUND_CTRL -- requirements
Module: bid_round_ctrl

---
 rtl/bids22_pkg.sv | 43 ++++
 rtl/bid_round_timer.sv | 27 ++
 rtl/bid_round_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_bid_round_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bids22_pkg.sv
// rtl/bids22_pkg.sv - opcodes, controller states, winner codes and error codes for the bid round controller
package bids22_pkg;

  typedef enum logic [3:0] {
    OP_NOOP      = 4'd0,
    OP_UNLOCK    = 4'd1,
    OP_LOCK      = 4'd2,
    OP_LOADX     = 4'd3,
    OP_LOADY     = 4'd4,
    OP_LOADZ     = 4'd5,
    OP_SETMASK   = 4'd6,
    OP_SETTIMER  = 4'd7,
    OP_BIDCHARGE = 4'd8
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LDX, ST_LDY, ST_LDZ, ST_MASK, ST_TMR, ST_COST,
    ST_LOCK, ST_RUN, ST_STOP, ST_WAITRES, ST_UNLK, ST_FIN
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_X    = 2'd1,
    WIN_Y    = 2'd2,
    WIN_Z    = 2'd3
  } winner_e;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_DUP_BID = 3'b101;

  // A winner is only reported when exactly one flag is set and no duplicate bid was flagged.
  function automatic winner_e decode_winner(input logic x, input logic y, input logic z,
                                            input logic [2:0] err);
    if (err == ERR_DUP_BID) return WIN_NONE;
    case ({z, y, x})
      3'b001:  return WIN_X;
      3'b010:  return WIN_Y;
      3'b100:  return WIN_Z;
      default: return WIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bid_round_timer.sv
// rtl/bid_round_timer.sv - loadable down-counter with zero flag for run length and result timeout
module bid_round_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bid_round_ctrl.sv
// rtl/bid_round_ctrl.sv - auction round-set controller; win statistics enabled by BID_CTRL_STATS_EN
module bid_round_ctrl #(
  parameter logic [31:0] UNLOCK_KEY     = 32'h0F0F0F0F,
  parameter int unsigned ROUND_CYCLES   = 16,
  parameter int unsigned RESULT_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_x_value,
  input  logic [31:0] cfg_y_value,
  input  logic [31:0] cfg_z_value,
  input  logic [2:0]  cfg_mask,
  input  logic [31:0] cfg_timer,
  input  logic [31:0] cfg_cost,
  input  logic [7:0]  cfg_rounds,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  input  logic        ready,
  input  logic [2:0]  err,
  input  logic        roundOver,
  input  logic [31:0] maxBid,
  input  logic        X_win,
  input  logic        Y_win,
  input  logic        Z_win,
  output logic        res_valid,
  output logic [1:0]  res_winner,
  output logic [31:0] res_maxbid,
  output logic [7:0]  res_round,
  output logic        busy,
  output logic        done,
  output logic        cmd_err,
  output logic        timeout_err,
  output logic [15:0] stat_x_wins,
  output logic [15:0] stat_y_wins,
  output logic [15:0] stat_z_wins
);
  import bids22_pkg::*;

  state_e      state, next_state, cmd_next;
  op_e         op, cmd_op;
  logic [31:0] data, cmd_data, tmr_value;
  logic [31:0] x_q, y_q, z_q, timer_q, cost_q;
  logic [2:0]  mask_q;
  logic [7:0]  nrounds, round_idx;
  logic        issued_q, issue, is_cmd, start, abort, more_rounds;
  logic        tmr_load, tmr_en, tmr_zero;

  bid_round_timer #(.W(32)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  // An engine error is only meaningful on the cycle right after a command was accepted.
  assign abort       = issued_q && (err != ERR_NONE) && (state != ST_FIN);
  assign more_rounds = ({1'b0, round_idx} + 9'd1) < {1'b0, nrounds};

  always_comb begin
    next_state = state;
    op         = OP_NOOP;
    data       = '0;
    start      = 1'b0;
    issue      = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_en     = 1'b0;
    is_cmd     = 1'b0;
    cmd_op     = OP_NOOP;
    cmd_data   = '0;
    cmd_next   = state;
    case (state)
      ST_IDLE: if (cfg_valid) next_state = ST_LDX;
      ST_LDX:  begin is_cmd = 1'b1; cmd_op = OP_LOADX;     cmd_data = x_q;             cmd_next = ST_LDY;  end
      ST_LDY:  begin is_cmd = 1'b1; cmd_op = OP_LOADY;     cmd_data = y_q;             cmd_next = ST_LDZ;  end
      ST_LDZ:  begin is_cmd = 1'b1; cmd_op = OP_LOADZ;     cmd_data = z_q;             cmd_next = ST_MASK; end
      ST_MASK: begin is_cmd = 1'b1; cmd_op = OP_SETMASK;   cmd_data = {29'd0, mask_q}; cmd_next = ST_TMR;  end
      ST_TMR:  begin is_cmd = 1'b1; cmd_op = OP_SETTIMER;  cmd_data = timer_q;         cmd_next = ST_COST; end
      ST_COST: begin is_cmd = 1'b1; cmd_op = OP_BIDCHARGE; cmd_data = cost_q;          cmd_next = ST_LOCK; end
      ST_LOCK: begin
        is_cmd    = 1'b1; cmd_op = OP_LOCK; cmd_data = UNLOCK_KEY; cmd_next = ST_RUN;
        tmr_load  = ready;
        tmr_value = 32'(ROUND_CYCLES - 1);
      end
      ST_RUN: begin
        start = 1'b1;
        if (tmr_zero) next_state = ST_STOP;
        else          tmr_en     = 1'b1;
      end
      ST_STOP: begin
        next_state = ST_WAITRES;
        tmr_load   = 1'b1;
        tmr_value  = 32'(RESULT_TIMEOUT - 1);
      end
      ST_WAITRES: begin
        if (roundOver) begin
          if (more_rounds) begin
            next_state = ST_RUN;
            tmr_load   = 1'b1;
            tmr_value  = 32'(ROUND_CYCLES - 1);
          end else begin
            next_state = ST_UNLK;
          end
        end else if (tmr_zero) begin
          next_state = ST_UNLK;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_UNLK: begin is_cmd = 1'b1; cmd_op = OP_UNLOCK; cmd_data = UNLOCK_KEY; cmd_next = ST_FIN; end
      ST_FIN:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    if (is_cmd && ready) begin
      op         = cmd_op;
      data       = cmd_data;
      issue      = 1'b1;
      next_state = cmd_next;
    end
    if (abort) begin
      next_state = ST_IDLE;
      op         = OP_NOOP;
      data       = '0;
      start      = 1'b0;
      issue      = 1'b0;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      issued_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      timer_q     <= '0;
      cost_q      <= '0;
      mask_q      <= '0;
      nrounds     <= 8'd1;
      round_idx   <= '0;
      res_valid   <= 1'b0;
      res_winner  <= WIN_NONE;
      res_maxbid  <= '0;
      res_round   <= '0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= next_state;
      issued_q  <= issue;
      res_valid <= 1'b0;
      if (state == ST_IDLE && cfg_valid) begin
        x_q         <= cfg_x_value;
        y_q         <= cfg_y_value;
        z_q         <= cfg_z_value;
        timer_q     <= cfg_timer;
        cost_q      <= cfg_cost;
        mask_q      <= cfg_mask;
        nrounds     <= (cfg_rounds == 8'd0) ? 8'd1 : cfg_rounds;
        round_idx   <= '0;
        cmd_err     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (abort) cmd_err <= 1'b1;
      if (state == ST_WAITRES) begin
        if (roundOver) begin
          res_valid  <= 1'b1;
          res_winner <= decode_winner(X_win, Y_win, Z_win, err);
          res_maxbid <= maxBid;
          res_round  <= round_idx;
          if (more_rounds) round_idx <= round_idx + 8'd1;
        end else if (tmr_zero) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  assign C_op      = op;
  assign C_data    = data;
  assign C_start   = start;
  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);

`ifdef BID_CTRL_STATS_EN
  logic [15:0] x_wins, y_wins, z_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_wins <= '0;
      y_wins <= '0;
      z_wins <= '0;
    end else if (res_valid) begin
      case (res_winner)
        WIN_X:   if (x_wins != 16'hFFFF) x_wins <= x_wins + 16'd1;
        WIN_Y:   if (y_wins != 16'hFFFF) y_wins <= y_wins + 16'd1;
        WIN_Z:   if (z_wins != 16'hFFFF) z_wins <= z_wins + 16'd1;
        default: ;
      endcase
    end
  end

  assign stat_x_wins = x_wins;
  assign stat_y_wins = y_wins;
  assign stat_z_wins = z_wins;
`else
  assign stat_x_wins = '0;
  assign stat_y_wins = '0;
  assign stat_z_wins = '0;
`endif

endmodule

// File: tb/tb_bid_round_ctrl.sv
// tb/tb_bid_round_ctrl.sv - directed scoreboard bench for bid_round_ctrl (BID_CTRL_STATS_EN aware)
module tb_bid_round_ctrl;

  localparam logic [31:0] KEY = 32'h0F0F0F0F;
  localparam int RC = 16;
  localparam int RT = 8;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cfg_valid = 1'b0, cfg_ready;
  logic [31:0] cfg_x_value = '0, cfg_y_value = '0, cfg_z_value = '0;
  logic [2:0]  cfg_mask = '0;
  logic [31:0] cfg_timer = '0, cfg_cost = '0;
  logic [7:0]  cfg_rounds = '0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready = 1'b1;
  logic [2:0]  err = '0;
  logic        roundOver = 1'b0;
  logic [31:0] maxBid = '0;
  logic        X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
  logic        res_valid;
  logic [1:0]  res_winner;
  logic [31:0] res_maxbid;
  logic [7:0]  res_round;
  logic        busy, done, cmd_err, timeout_err;
  logic [15:0] stat_x_wins, stat_y_wins, stat_z_wins;

  int checks = 0, errors = 0, cyc = 0, runs = 0, run_len = 0, res_count = 0;
  bit prev_res = 0;
  logic [35:0] exp_ops[$];
  logic [41:0] exp_res[$];
  int          issue_cyc[$];
  logic [35:0] mon_op;
  logic [41:0] mon_res;

  bid_round_ctrl dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x_value(cfg_x_value), .cfg_y_value(cfg_y_value), .cfg_z_value(cfg_z_value),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost), .cfg_rounds(cfg_rounds),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .ready(ready), .err(err),
    .roundOver(roundOver), .maxBid(maxBid), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
    .res_valid(res_valid), .res_winner(res_winner), .res_maxbid(res_maxbid), .res_round(res_round),
    .busy(busy), .done(done), .cmd_err(cmd_err), .timeout_err(timeout_err),
    .stat_x_wins(stat_x_wins), .stat_y_wins(stat_y_wins), .stat_z_wins(stat_z_wins)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the opcode and result scoreboards as the DUT produces them.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (C_op !== 4'd0) begin
        issue_cyc.push_back(cyc);
        if (exp_ops.size() == 0) check("op_unexpected", 32'(C_op), 0);
        else begin
          mon_op = exp_ops.pop_front();
          check("op_code", 32'(C_op), 32'(mon_op[35:32]));
          check("op_data", C_data, mon_op[31:0]);
        end
      end
      if (!busy) check("idle_data", C_data, 0);
      if (C_start === 1'b1) run_len++;
      else if (run_len != 0) begin
        check("run_len", 32'(run_len), 32'(RC));
        runs++;
        run_len = 0;
      end
      if (prev_res) check("res_pulse", 32'(res_valid), 0);
      if (res_valid === 1'b1) begin
        res_count++;
        if (exp_res.size() == 0) check("res_unexpected", 32'(res_valid), 0);
        else begin
          mon_res = exp_res.pop_front();
          check("res_winner", 32'(res_winner), 32'(mon_res[41:40]));
          check("res_maxbid", res_maxbid, mon_res[39:8]);
          check("res_round", 32'(res_round), 32'(mon_res[7:0]));
        end
      end
      prev_res = (res_valid === 1'b1);
    end else begin
      run_len  = 0;
      prev_res = 0;
    end
  end

  task automatic request(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic [2:0] m, input logic [31:0] t, input logic [31:0] c,
                         input logic [7:0] r, input int n_ops);
    logic [35:0] seq[8];
    seq = '{{4'd3, x}, {4'd4, y}, {4'd5, z}, {4'd6, 29'd0, m},
            {4'd7, t}, {4'd8, c}, {4'd2, KEY}, {4'd1, KEY}};
    issue_cyc.delete();
    for (int i = 0; i < n_ops; i++) exp_ops.push_back(seq[i]);
    cfg_x_value = x; cfg_y_value = y; cfg_z_value = z; cfg_mask = m;
    cfg_timer = t; cfg_cost = c; cfg_rounds = r; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_run_end(input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 400) begin
      @(negedge clk);
      if (C_start === 1'b1) seen = 1;
      else if (seen) break;
      n++;
    end
    check(tag, 32'(n < 400), 1);
  endtask

  task automatic give_result(input logic x, input logic y, input logic z, input logic [31:0] mb,
                             input logic [2:0] e, input logic [1:0] ew, input logic [7:0] er);
    step();
    roundOver = 1'b1; X_win = x; Y_win = y; Z_win = z; maxBid = mb; err = e;
    exp_res.push_back({ew, mb, er});
    step();
    roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0; maxBid = '0; err = '0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
    end
    check(tag, 32'(n < 100), 1);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("idle_ready", 32'(cfg_ready), 1);
  endtask

  initial begin
    int runs_before, res_before, n, exp_x, exp_y;
    repeat (2) step();
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_c_op", 32'(C_op), 0);
    check("rst_c_data", C_data, 0);
    check("rst_c_start", 32'(C_start), 0);
    check("rst_res", {res_valid, res_winner, res_round, done, cmd_err, timeout_err}, 0);
    check("rst_maxbid", res_maxbid, 0);
    check("rst_stats", {stat_x_wins, stat_y_wins}, 0);
    reset = 1'b0;

    // Plain single round: Y wins with 42.
    request(100, 100, 100, 3'd7, 32'd500, 32'd5, 8'd1, 8);
    check("s1_busy", 32'(busy), 1);
    check("s1_cfg_ready", 32'(cfg_ready), 0);
    wait_run_end("s1_run");
    give_result(1'b0, 1'b1, 1'b0, 32'd42, 3'b000, 2'd2, 8'd0);
    wait_done("s1_done");
    check("s1_op_span", 32'(issue_cyc[6] - issue_cyc[0]), 6);
    check("s1_ops_left", 32'(exp_ops.size()), 0);
    check("s1_res_count", 32'(res_count), 1);

    // ready held low for three LDY cycles; rounds=0 behaves as one round.
    request(1, 2, 3, 3'b011, 32'd10, 32'd20, 8'd0, 8);
    step();
    ready = 1'b0;
    repeat (3) step();
    ready = 1'b1;
    wait_run_end("s2_run");
    give_result(1'b1, 1'b0, 1'b0, 32'd77, 3'b000, 2'd1, 8'd0);
    wait_done("s2_done");
    check("s2_ldy_gap", 32'(issue_cyc[1] - issue_cyc[0]), 4);
    check("s2_op_span", 32'(issue_cyc[6] - issue_cyc[0]), 9);
    check("s2_ops_left", 32'(exp_ops.size()), 0);

    // Engine error right after SetTimer aborts the set before Lock.
    runs_before = runs;
    request(5, 6, 7, 3'b001, 32'd8, 32'd9, 8'd1, 5);
    repeat (5) step();
    err = 3'b100;
    step();
    err = 3'b000;
    check("s3_cmd_err", 32'(cmd_err), 1);
    check("s3_busy", 32'(busy), 0);
    check("s3_cfg_ready", 32'(cfg_ready), 1);
    repeat (20) step();
    check("s3_no_run", 32'(runs), 32'(runs_before));
    check("s3_ops_left", 32'(exp_ops.size()), 0);
    check("s3_cmd_err_sticky", 32'(cmd_err), 1);

    // Two rounds: multiple flags, then a single flag masked by a duplicate-bid error.
    request(9, 9, 9, 3'b111, 32'd1, 32'd1, 8'd2, 8);
    check("s4_cmd_err_clr", 32'(cmd_err), 0);
    wait_run_end("s4_run0");
    give_result(1'b1, 1'b1, 1'b0, 32'd10, 3'b000, 2'd0, 8'd0);
    wait_run_end("s4_run1");
    give_result(1'b0, 1'b0, 1'b1, 32'd11, 3'b101, 2'd0, 8'd1);
    wait_done("s4_done");
    check("s4_ops_left", 32'(exp_ops.size()), 0);

    // Three rounds, second round never reports: timeout and unlock.
    res_before = res_count;
    request(4, 4, 4, 3'b111, 32'd2, 32'd3, 8'd3, 8);
    wait_run_end("s5_run0");
    give_result(1'b1, 1'b0, 1'b0, 32'd55, 3'b000, 2'd1, 8'd0);
    wait_run_end("s5_run1");
    n = 0;
    while (n < 50 && timeout_err !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("s5_timeout_lat", 32'(n), 32'(RT + 1));
    wait_done("s5_done");
    check("s5_timeout_err", 32'(timeout_err), 1);
    check("s5_res_count", 32'(res_count - res_before), 1);
    check("s5_ops_left", 32'(exp_ops.size()), 0);

`ifdef BID_CTRL_STATS_EN
    exp_x = 2;
    exp_y = 1;
`else
    exp_x = 0;
    exp_y = 0;
`endif
    check("stat_x", 32'(stat_x_wins), 32'(exp_x));
    check("stat_y", 32'(stat_y_wins), 32'(exp_y));
    check("stat_z", 32'(stat_z_wins), 0);

    // Reset in the middle of a round.
    request(7, 7, 7, 3'b111, 32'd1, 32'd1, 8'd1, 7);
    check("s6_tmo_clr", 32'(timeout_err), 0);
    n = 0;
    while (n < 50 && C_start !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check("s6_run_seen", 32'(n < 50), 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("s6_c_start", 32'(C_start), 0);
    check("s6_busy", 32'(busy), 0);
    check("s6_cfg_ready", 32'(cfg_ready), 1);
    check("s6_c_op", 32'(C_op), 0);
    check("s6_stats", {stat_x_wins, stat_y_wins}, 0);
    reset = 1'b0;
    step();
    check("s6_ops_left", 32'(exp_ops.size()), 0);
    check("res_left", 32'(exp_res.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
